// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared VGA 640x480@60 timing constants and types.
//                Default porch/sync widths, derived line/frame totals and
//                sync window boundaries (start inclusive, end exclusive).
//                The optional sync delay stage is enabled by defining
//                VGA_SYNC_DELAY_EN when building vga_timing_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FP     = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BP     = 48;
    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 33;

    localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;
    localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;

    localparam int c_HS_START = c_H_ACTIVE + c_H_FP;
    localparam int c_HS_END   = c_H_ACTIVE + c_H_FP + c_H_SYNC;
    localparam int c_VS_START = c_V_ACTIVE + c_V_FP;
    localparam int c_VS_END   = c_V_ACTIVE + c_V_FP + c_V_SYNC;

    // Reset value of the packed {hs, vs, blank, frame_start} flag vector.
    localparam logic [3:0] c_FLAGS_RST = 4'b1100;

endpackage
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_delay
//  Description : Single register stage of parameterised width with a
//                synchronous, active-high reset to RESET_VALUE.
//  Ports       : clk  - clock (posedge)
//                rst  - synchronous active-high reset
//                i_d  - data in
//                o_q  - data out, one cycle later
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_delay #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing generator (640x480@60 by default).
//                Free-running pixel/line counters plus registered hs, vs,
//                blank and frame_start aligned with DrawX/DrawY, and an
//                8-bit frame counter.
//                Define VGA_SYNC_DELAY_EN to delay hs/vs/blank/frame_start
//                by one extra cycle relative to DrawX/DrawY.
//  Ports       : vga_clk     - pixel clock, posedge
//                reset       - synchronous active-high reset
//                DrawX/DrawY - current horizontal/vertical position
//                hs, vs      - active-low syncs
//                blank       - 1 in the visible region
//                sync        - tied 0
//                frame_start - one-cycle pulse at pixel (0,0)
//                frame_cnt   - frame counter, wraps 255 -> 0
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam coord_t c_h_last   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t c_v_last   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t c_h_active = coord_t'(H_ACTIVE);
    localparam coord_t c_v_active = coord_t'(V_ACTIVE);
    localparam coord_t c_hs_start = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t c_hs_end   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t c_vs_start = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t c_vs_end   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t     r_hc;
    coord_t     r_vc;
    logic [7:0] r_frame_cnt;
    logic [3:0] r_flags;        // {hs, vs, blank, frame_start}

    coord_t     w_hc_next;
    coord_t     w_vc_next;
    logic       w_h_wrap;
    logic       w_frame_wrap;
    logic [3:0] w_flags_next;
    logic [3:0] w_flags_out;

    // Flags are decoded from the next counter values so that, once
    // registered, they describe the same pixel that DrawX/DrawY show.
    always_comb begin
        w_h_wrap     = (r_hc == c_h_last);
        w_frame_wrap = w_h_wrap && (r_vc == c_v_last);
        w_hc_next    = w_h_wrap ? '0 : r_hc + 10'd1;
        w_vc_next    = r_vc;
        if (w_h_wrap) begin
            w_vc_next = (r_vc == c_v_last) ? '0 : r_vc + 10'd1;
        end
        w_flags_next[3] = !((w_hc_next >= c_hs_start) && (w_hc_next < c_hs_end));
        w_flags_next[2] = !((w_vc_next >= c_vs_start) && (w_vc_next < c_vs_end));
        w_flags_next[1] = (w_hc_next < c_h_active) && (w_vc_next < c_v_active);
        w_flags_next[0] = w_frame_wrap;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hc        <= '0;
            r_vc        <= '0;
            r_flags     <= c_FLAGS_RST;
            r_frame_cnt <= '0;
        end else begin
            r_hc    <= w_hc_next;
            r_vc    <= w_vc_next;
            r_flags <= w_flags_next;
            if (w_frame_wrap) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    vga_sync_delay #(
        .WIDTH       (4),
        .RESET_VALUE (c_FLAGS_RST)
    ) u_sync_delay (
        .clk (vga_clk),
        .rst (reset),
        .i_d (r_flags),
        .o_q (w_flags_out)
    );
`else
    assign w_flags_out = r_flags;
`endif

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign hs          = w_flags_out[3];
    assign vs          = w_flags_out[2];
    assign blank       = w_flags_out[1];
    assign frame_start = w_flags_out[0];
    assign frame_cnt   = r_frame_cnt;
    assign sync        = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. A default-size
//                instance is checked against a table of hand-derived line
//                checkpoints; a reduced-size instance (15x8 raster) is
//                checked cycle by cycle against a scoreboard model over
//                257 frames, plus mid-frame reset inside both sync pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
    localparam bit c_DLY = 1'b1;
`else
    localparam bit c_DLY = 1'b0;
`endif

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       rst_b = 1'b1;
    logic       rst_s = 1'b1;
    logic [9:0] x_b, y_b, x_s, y_s;
    logic       hs_b, vs_b, blank_b, sync_b, fs_b;
    logic       hs_s, vs_s, blank_s, sync_s, fs_s;
    logic [7:0] fc_b, fc_s;

    vga_timing_gen u_big (
        .vga_clk(clk), .reset(rst_b), .DrawX(x_b), .DrawY(y_b),
        .hs(hs_b), .vs(vs_b), .blank(blank_b), .sync(sync_b),
        .frame_start(fs_b), .frame_cnt(fc_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .vga_clk(clk), .reset(rst_s), .DrawX(x_s), .DrawY(y_s),
        .hs(hs_s), .vs(vs_s), .blank(blank_s), .sync(sync_s),
        .frame_start(fs_s), .frame_cnt(fc_s)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- table for the default-size instance ----------------
    typedef struct {
        logic       rst;
        int         ncyc;
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] fl;      // {hs, vs, blank, frame_start}
        logic [3:0] fl_dly;  // same, with the optional extra stage
        logic [7:0] fc;
    } vec_t;

    vec_t vecs[14];

    // ---------------- scoreboard for the reduced instance ----------------
    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] fl;
        logic [7:0] fc;
    } exp_t;

    exp_t sb[$];
    int   m_x, m_y, m_fc;
    logic [3:0] m_prev = 4'b1100;

    // 15x8 raster: hs low x=10..12, vs low y=5..6, visible x<8 && y<4.
    function automatic logic [3:0] flags_of(input int x, input int y, input logic fs);
        flags_of = {!(x >= 10 && x < 13), !(y >= 5 && y < 7), (x < 8 && y < 4), fs};
    endfunction

    task automatic small_cycle(input logic r);
        logic [3:0] u;
        logic       fs;
        exp_t       e;
        exp_t       g;
        rst_s = r;
        @(posedge clk);
        if (r) begin
            m_x = 0; m_y = 0; m_fc = 0;
            u = 4'b1100;
        end else begin
            m_x++;
            if (m_x == 15) begin
                m_x = 0;
                m_y++;
                if (m_y == 8) m_y = 0;
            end
            fs = (m_x == 0 && m_y == 0);
            if (fs) m_fc = (m_fc + 1) % 256;
            u = flags_of(m_x, m_y, fs);
        end
        e.x  = 10'(m_x);
        e.y  = 10'(m_y);
        e.fc = 8'(m_fc);
        e.fl = c_DLY ? (r ? 4'b1100 : m_prev) : u;
        m_prev = u;
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        chk("small_x",     {22'd0, x_s}, {22'd0, g.x});
        chk("small_y",     {22'd0, y_s}, {22'd0, g.y});
        chk("small_flags", {28'd0, hs_s, vs_s, blank_s, fs_s}, {28'd0, g.fl});
        chk("small_fc",    {24'd0, fc_s}, {24'd0, g.fc});
    endtask

    initial begin
        int cyc;
        int first_fs;
        int prev_fs;
        int n_fs;
        int bad_int;
        int vs_low;
        int hs_low;
        bit found;

        //            rst  n    x       y      fl       fl_dly   fc
        vecs[0]  = '{1'b1, 5,   10'd0,   10'd0, 4'b1100, 4'b1100, 8'd0};
        vecs[1]  = '{1'b0, 1,   10'd1,   10'd0, 4'b1110, 4'b1100, 8'd0};
        vecs[2]  = '{1'b0, 638, 10'd639, 10'd0, 4'b1110, 4'b1110, 8'd0};
        vecs[3]  = '{1'b0, 1,   10'd640, 10'd0, 4'b1100, 4'b1110, 8'd0};
        vecs[4]  = '{1'b0, 15,  10'd655, 10'd0, 4'b1100, 4'b1100, 8'd0};
        vecs[5]  = '{1'b0, 1,   10'd656, 10'd0, 4'b0100, 4'b1100, 8'd0};
        vecs[6]  = '{1'b0, 1,   10'd657, 10'd0, 4'b0100, 4'b0100, 8'd0};
        vecs[7]  = '{1'b0, 94,  10'd751, 10'd0, 4'b0100, 4'b0100, 8'd0};
        vecs[8]  = '{1'b0, 1,   10'd752, 10'd0, 4'b1100, 4'b0100, 8'd0};
        vecs[9]  = '{1'b0, 47,  10'd799, 10'd0, 4'b1100, 4'b1100, 8'd0};
        vecs[10] = '{1'b0, 1,   10'd0,   10'd1, 4'b1110, 4'b1100, 8'd0};
        vecs[11] = '{1'b0, 1,   10'd1,   10'd1, 4'b1110, 4'b1110, 8'd0};
        vecs[12] = '{1'b1, 1,   10'd0,   10'd0, 4'b1100, 4'b1100, 8'd0};
        vecs[13] = '{1'b0, 1,   10'd1,   10'd0, 4'b1110, 4'b1100, 8'd0};

        for (int i = 0; i < 14; i++) begin
            rst_b = vecs[i].rst;
            repeat (vecs[i].ncyc) @(posedge clk);
            #1;
            chk($sformatf("big_x[%0d]", i), {22'd0, x_b}, {22'd0, vecs[i].x});
            chk($sformatf("big_y[%0d]", i), {22'd0, y_b}, {22'd0, vecs[i].y});
            chk($sformatf("big_flags[%0d]", i), {28'd0, hs_b, vs_b, blank_b, fs_b},
                {28'd0, (c_DLY ? vecs[i].fl_dly : vecs[i].fl)});
            chk($sformatf("big_fc_sync[%0d]", i), {23'd0, sync_b, fc_b}, {23'd0, 1'b0, vecs[i].fc});
        end

        // Reduced raster: 120 cycles per frame, run 257 frames.
        repeat (3) small_cycle(1'b1);
        first_fs = -1; prev_fs = -1; n_fs = 0; bad_int = 0; vs_low = 0; hs_low = 0;
        for (cyc = 1; cyc <= 257 * 120 + 1; cyc++) begin
            small_cycle(1'b0);
            if (cyc <= 120 + int'(c_DLY) && cyc > int'(c_DLY)) begin
                if (!vs_s) vs_low++;
                if (!hs_s) hs_low++;
            end
            if (fs_s) begin
                n_fs++;
                if (first_fs < 0) first_fs = cyc;
                if (prev_fs >= 0 && cyc - prev_fs != 120) bad_int++;
                prev_fs = cyc;
                if (n_fs == 256) chk("fc_wrap_at_256", {24'd0, fc_s}, 32'd0);
                if (n_fs == 255) chk("fc_at_255",      {24'd0, fc_s}, 32'd255);
            end
        end
        chk("first_fs_cycle", first_fs, 120 + int'(c_DLY));
        chk("fs_count",       n_fs,     257);
        chk("fs_bad_interval", bad_int, 0);
        chk("vs_low_cycles",  vs_low,   30);
        chk("hs_low_cycles",  hs_low,   24);
        chk("fc_after_257",   {24'd0, fc_s}, 32'd1);

        // Walk to (11,5), inside both sync pulses, then reset.
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            small_cycle(1'b0);
            if (m_x == 11 && m_y == 5) found = 1'b1;
        end
        chk("reach_11_5", {31'd0, found}, 32'd1);
        chk("pre_reset_fc_nonzero", {31'd0, (fc_s != 8'd0)}, 32'd1);
        small_cycle(1'b1);
        chk("midrst_x",  {22'd0, x_s}, 32'd0);
        chk("midrst_y",  {22'd0, y_s}, 32'd0);
        chk("midrst_hs", {31'd0, hs_s}, 32'd1);
        chk("midrst_vs", {31'd0, vs_s}, 32'd1);
        chk("midrst_fc", {24'd0, fc_s}, 32'd0);
        repeat (5) small_cycle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the VGA raster timing that every sprite and background renderer consumes: DrawX, DrawY, blank, hs, vs.
- Free-running horizontal and vertical pixel counters, all on vga_clk (25 MHz, 640x480@60).
- Also provides a one-cycle frame_start strobe and an 8-bit frame counter that game and animation logic use for sprite frame selection.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- blank  out  1  1 = visible pixel (renderers drive colour only when blank=1); 0 = blanking interval
- sync  out  1  constant 0
- frame_start  out  1  one-cycle pulse at the first pixel of each frame
- frame_cnt  out  8  frame counter, increments once per frame

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). All widths are 10 bits; compare against derived localparams, with no runtime arithmetic beyond +1.
- Horizontal counter hc: increments every cycle. At H_TOTAL-1 it wraps to 0 on the next cycle.
- Vertical counter vc: increments only when hc wraps. vc = V_TOTAL-1 together with hc = H_TOTAL-1 wraps vc to 0.
- DrawX = hc and DrawY = vc, driven directly from registers.
- hs, vs, blank and frame_start are registers computed from the next counter values, so they are exactly aligned with DrawX/DrawY in the same cycle. There is no combinational path from counters to outputs.
  - hs = 0 iff H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs = 0 iff V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491).
  - blank = 1 iff DrawX < H_ACTIVE and DrawY < V_ACTIVE.
  - frame_start = 1 iff DrawX = 0 and DrawY = 0, except during and at exit from reset (see below).
- frame_cnt: increments on the same edge that moves the counters to (0,0), i.e. aligned with frame_start. Wraps 255 -> 0.
- Reset values: hc = 0, vc = 0, hs = 1, vs = 1, blank = 0, frame_start = 0, frame_cnt = 0.
- Exit from reset: the first active edge moves the counters to (1,0) with blank = 1. Pixel (0,0) of the first frame is not displayed, and no frame_start is issued for it. The first frame_start occurs at the wrap to (0,0) after one full frame.
- Reset mid-frame: on the next edge all state returns to reset values regardless of position. No partial sync pulse is extended; hs/vs go to 1 immediately.
- Timing invariants: exactly one frame_start per 420000 cycles; exactly 800 cycles per line; hs low for 96 cycles; vs low for 1600 cycles.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN.
- Defined: hs, vs, blank and frame_start pass through one additional register stage. They lag DrawX/DrawY by one cycle, matching renderers that register colour one cycle after address generation. Reset value of the delay stage equals the output reset values above. DrawX, DrawY and frame_cnt are not delayed.
- Undefined: no extra stage; alignment as specified in Behaviour.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants and the derived H_TOTAL/V_TOTAL;
  - HS_START/HS_END/VS_START/VS_END;
  - typedef coord_t = logic [9:0].
- Sub-module vga_sync_delay: parameterised-width, single-stage register with synchronous reset value. It is instantiated only under VGA_SYNC_DELAY_EN.

Test Plan:
- Reset held 5 cycles, then released -> during reset DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_cnt=0; first edge after release gives DrawX=1, blank=1.
- Run 1 line -> hs falls at DrawX=656, rises at DrawX=752; blank falls at DrawX=640; DrawX wraps 799->0 and DrawY increments 0->1.
- Run 1 full frame -> vs low exactly for DrawY 490..491 (1600 cycles); blank=0 for all DrawY>=480; frame_start pulses once at (0,0) after 420000 cycles.
- Run 256 frames -> frame_cnt steps by 1 on each frame_start and wraps 255->0 on the 256th.
- Assert reset at DrawX=700, DrawY=491 (inside both sync pulses) -> next cycle hs=1, vs=1, counters 0, frame_cnt=0.
- With VGA_SYNC_DELAY_EN defined, repeat the line test -> hs falls when DrawX=657 and blank falls when DrawX=641; DrawX/DrawY sequence unchanged.
